// File: rtl/pwm_capture.sv
// pwm_capture: measures the period and high time of an external PWM waveform.
// Both results are counted in clk cycles between synchronized edges of pwm_in.
// A saturating counter flags stuck-high or stuck-low inputs as a sticky timeout.
module pwm_capture #(
    parameter int bit_width = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwm_in,
    output logic [bit_width-1:0] period_out,
    output logic [bit_width-1:0] high_out,
    output logic                 valid,
    output logic                 timeout,
    output logic                 stuck_level
);

    // Largest count the counter can hold. A period this long is still measurable.
    localparam logic [bit_width-1:0] CNT_MAX = {bit_width{1'b1}};
    localparam logic [bit_width-1:0] CNT_ONE = {{(bit_width-1){1'b0}}, 1'b1};
    localparam int                   SYNC_STAGES = 2;

    // IDLE waits for a rise to start a period. ARMED counts a period in progress.
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // Synchronizer chain. Element 0 samples the asynchronous pin.
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   s_d_reg;
    logic                   s;
    logic                   rise;
    logic                   fall;

    state_t                 state_reg, state_next;
    logic [bit_width-1:0]   cnt_reg, cnt_next;
    logic [bit_width-1:0]   high_cap_reg, high_cap_next;
    logic [bit_width-1:0]   period_reg, period_next;
    logic [bit_width-1:0]   high_reg, high_next;
    logic                   valid_reg, valid_next;
    logic                   timeout_reg, timeout_next;
    logic                   stuck_reg, stuck_next;

    // Each stage takes the previous one. The first stage takes the raw pin.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = pwm_in;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    assign s    = sync_reg[SYNC_STAGES-1];
    assign rise = s & ~s_d_reg;
    assign fall = ~s & s_d_reg;

    // Synchronizer and edge-detect flops. Reset clears them, so a high input
    // at reset release shows up as a rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_reg <= '0;
            s_d_reg  <= 1'b0;
        end else begin
            sync_reg <= sync_next;
            s_d_reg  <= s;
        end
    end

    // Free-running period counter. A rise restarts it at 1, so that the count
    // at the next rise equals the period. It saturates instead of wrapping.
    always_comb begin
        cnt_next = cnt_reg;
        if (rise) begin
            cnt_next = CNT_ONE;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    // Measurement FSM. It produces the next state and every result register.
    // A rise takes priority over a saturated counter, so a period of exactly
    // CNT_MAX is reported as a measurement and not as a timeout.
    always_comb begin
        state_next    = state_reg;
        high_cap_next = high_cap_reg;
        period_next   = period_reg;
        high_next     = high_reg;
        valid_next    = 1'b0;
        timeout_next  = timeout_reg;
        stuck_next    = stuck_reg;

        case (state_reg)
            IDLE: begin
                // The first rise only starts a period. A fall here is meaningless.
                if (rise) begin
                    state_next = ARMED;
                end
            end

            ARMED: begin
                // The high time is the count at the fall. It stays fresh because
                // a fall always comes before the next rise.
                if (fall) begin
                    high_cap_next = cnt_reg;
                end
                if (rise) begin
                    period_next  = cnt_reg;
                    high_next    = high_cap_reg;
                    valid_next   = 1'b1;
                    timeout_next = 1'b0;
                end else if (cnt_reg == CNT_MAX) begin
                    // The period is too long to measure. Keep the last results,
                    // record the stuck level and wait for a fresh rise.
                    timeout_next = 1'b1;
                    stuck_next   = s;
                    state_next   = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and result registers. Reset discards any partial period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            high_cap_reg <= '0;
            period_reg   <= '0;
            high_reg     <= '0;
            valid_reg    <= 1'b0;
            timeout_reg  <= 1'b0;
            stuck_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            high_cap_reg <= high_cap_next;
            period_reg   <= period_next;
            high_reg     <= high_next;
            valid_reg    <= valid_next;
            timeout_reg  <= timeout_next;
            stuck_reg    <= stuck_next;
        end
    end

    assign period_out  = period_reg;
    assign high_out    = high_reg;
    assign valid       = valid_reg;
    assign timeout     = timeout_reg;
    assign stuck_level = stuck_reg;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with bit_width=10 and a 10 ns clock.
// Inputs are driven 1 ns after each rising edge. Outputs are sampled at that same point.
module tb_pwm_capture;

    localparam int BW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pwm_in;
    logic [BW-1:0] period_out;
    logic [BW-1:0] high_out;
    logic          valid;
    logic          timeout;
    logic          stuck_level;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_capture #(.bit_width(BW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .period_out  (period_out),
        .high_out    (high_out),
        .valid       (valid),
        .timeout     (timeout),
        .stuck_level (stuck_level)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 ns past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison with an immediate assertion. A failure is reported on one line.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold pwm_in at a fixed level for n cycles. Count the valid pulses seen.
    task automatic hold(input logic lvl, input int n, output int nvalid);
        nvalid = 0;
        for (int i = 0; i < n; i++) begin
            pwm_in = lvl;
            tick();
            if (valid === 1'b1) nvalid++;
        end
    endtask

    // Drive nper periods with the given high time. Check every valid pulse
    // against the expected results. Return the index of the first valid pulse.
    task automatic run_wave(input string tag, input int period, input int high,
                            input int nper, input int exp_valids, output int first_valid);
        int nv;
        nv = 0;
        first_valid = -1;
        for (int p = 0; p < nper; p++) begin
            for (int i = 0; i < period; i++) begin
                pwm_in = (i < high) ? 1'b1 : 1'b0;
                tick();
                if (valid === 1'b1) begin
                    if (first_valid < 0) first_valid = p * period + i;
                    nv++;
                    check({tag, "_period"}, 32'(period_out), 32'(period));
                    check({tag, "_high"}, 32'(high_out), 32'(high));
                    check({tag, "_timeout_clr"}, 32'(timeout), 32'd0);
                end
            end
        end
        check({tag, "_nvalid"}, 32'(nv), 32'(exp_valids));
    endtask

    initial begin
        int nv;
        int fv;

        // Reset state.
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        hold(1'b0, 3, nv);
        check("rst_period", 32'(period_out), 32'd0);
        check("rst_high", 32'(high_out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_stuck", 32'(stuck_level), 32'd0);
        rst_n = 1'b1;
        hold(1'b0, 3, nv);
        check("idle_nvalid", 32'(nv), 32'd0);

        // Basic 100/25 waveform. The first rise only arms, so 4 rises give 3 results.
        // The second rise is driven at index 100 and its valid is seen at index 102.
        run_wave("s1", 100, 25, 4, 3, fv);
        check("s1_latency", 32'(fv), 32'd102);
        $display("s1: 100/25 x4 first_valid=%0d", fv);

        // Stuck low. The counter is at 98 now and reaches 1023 after 925 more
        // cycles. The timeout is seen one cycle later.
        hold(1'b0, 925, nv);
        check("s3_pre_nvalid", 32'(nv), 32'd0);
        check("s3_pre_timeout", 32'(timeout), 32'd0);
        hold(1'b0, 1, nv);
        check("s3_timeout", 32'(timeout), 32'd1);
        check("s3_stuck", 32'(stuck_level), 32'd0);
        check("s3_keep_period", 32'(period_out), 32'd100);
        check("s3_keep_high", 32'(high_out), 32'd25);
        check("s3_valid", 32'(valid), 32'd0);
        run_wave("s3_arm", 100, 25, 1, 0, fv);
        check("s3_arm_timeout", 32'(timeout), 32'd1);
        run_wave("s3_rearm", 100, 25, 2, 2, fv);
        check("s3_rearm_latency", 32'(fv), 32'd2);
        $display("s3: stuck low, timeout then re-arm first_valid=%0d", fv);

        // Reset in the middle of a period.
        hold(1'b1, 25, nv);
        check("s5_pre_nvalid", 32'(nv), 32'd1);
        hold(1'b0, 25, nv);
        check("s5_mid_nvalid", 32'(nv), 32'd0);
        rst_n = 1'b0;
        hold(1'b0, 1, nv);
        check("s5_rst_period", 32'(period_out), 32'd0);
        check("s5_rst_high", 32'(high_out), 32'd0);
        check("s5_rst_valid", 32'(valid), 32'd0);
        check("s5_rst_timeout", 32'(timeout), 32'd0);
        check("s5_rst_stuck", 32'(stuck_level), 32'd0);
        rst_n = 1'b1;
        hold(1'b0, 50, nv);
        check("s5_post_nvalid", 32'(nv), 32'd0);
        run_wave("s5", 100, 25, 3, 2, fv);
        check("s5_latency", 32'(fv), 32'd102);
        $display("s5: mid-period reset first_valid=%0d", fv);

        // Stuck high from reset. The rise at index 0 arms the counter at edge 2.
        // The counter then reaches 1023 and the timeout is seen at index 1025.
        rst_n = 1'b0;
        hold(1'b0, 2, nv);
        rst_n = 1'b1;
        hold(1'b1, 1025, nv);
        check("s4_pre_nvalid", 32'(nv), 32'd0);
        check("s4_pre_timeout", 32'(timeout), 32'd0);
        hold(1'b1, 1, nv);
        check("s4_timeout", 32'(timeout), 32'd1);
        check("s4_stuck", 32'(stuck_level), 32'd1);
        check("s4_valid", 32'(valid), 32'd0);
        check("s4_period", 32'(period_out), 32'd0);
        hold(1'b1, 100, nv);
        check("s4_post_nvalid", 32'(nv), 32'd0);
        check("s4_post_timeout", 32'(timeout), 32'd1);
        $display("s4: stuck high timeout=%0d stuck_level=%0d", timeout, stuck_level);

        // Toggle every cycle. A fall in IDLE is ignored. The last rise's valid
        // arrives two cycles after the loop ends.
        hold(1'b0, 5, nv);
        check("s6_idle_nvalid", 32'(nv), 32'd0);
        check("s6_idle_timeout", 32'(timeout), 32'd1);
        run_wave("s6_toggle", 2, 1, 20, 18, fv);
        check("s6_toggle_latency", 32'(fv), 32'd4);
        hold(1'b0, 1, nv);
        check("s6_tail_nvalid", 32'(nv), 32'd1);
        check("s6_tail_period", 32'(period_out), 32'd2);
        check("s6_tail_high", 32'(high_out), 32'd1);
        $display("s6: toggle period=%0d high=%0d", period_out, high_out);

        // A period of exactly 1023 cycles: the rise wins over saturation.
        // This is also the pwm_module waveform with max_value=1022 and duty=1.
        rst_n = 1'b0;
        hold(1'b0, 2, nv);
        rst_n = 1'b1;
        run_wave("s6_p1023", 1023, 1, 3, 2, fv);
        check("s6_p1023_latency", 32'(fv), 32'd1025);
        check("s6_p1023_timeout", 32'(timeout), 32'd0);
        $display("s6: period 1023 high 1 timeout=%0d", timeout);

        // Same period with duty=511.
        rst_n = 1'b0;
        hold(1'b0, 2, nv);
        rst_n = 1'b1;
        run_wave("s2_duty511", 1023, 511, 3, 2, fv);
        check("s2_latency", 32'(fv), 32'd1025);
        check("s2_period", 32'(period_out), 32'd1023);
        check("s2_high", 32'(high_out), 32'd511);
        $display("s2: period %0d high %0d", period_out, high_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
